// File: rtl/seq_pkg.sv
// Shared constants for the 1011 detector feed path: FSM encoding, default widths and fill bit.
package seq_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} ser_state_t;
  localparam int         SER_WIDTH    = 8;
  localparam logic       SER_IDLE_BIT = 1'b0;
  localparam logic [3:0] DET_PATTERN  = 4'b1011;
endpackage

// File: rtl/ser_hold_buf.sv
// One-word holding register: catches a word while the shifter is busy mid-word.
// Ready whenever empty; drains into the shifter when the shifter becomes free.
module ser_hold_buf import seq_pkg::*; #(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             free,
  output logic             in_ready,
  output logic             accept,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_reg
);
  assign in_ready = reset & ~hold_full;
  assign accept   = in_valid & in_ready;

  // A free shifter either drains the held word or takes in_data directly,
  // so the holding register only captures while a word is mid-flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (free) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= in_data;
      hold_full <= 1'b1;
    end
  end
endmodule

// File: rtl/bit_serializer_1011_feed.sv
// Parallel-to-serial feed for the 1011 detector: one bit per clock, back-to-back words,
// IDLE_BIT fill when starved. First bit appears the cycle after the accepting edge.
module bit_serializer_1011_feed import seq_pkg::*; #(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = SER_IDLE_BIT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);
  localparam int            BW   = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             free;
  logic             accept;
  logic             hold_full;
  logic [WIDTH-1:0] hold_reg;
  logic             head;

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST);
  assign free     = (state == ST_IDLE) || last_bit;
  assign head     = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .free      (free),
    .in_ready  (in_ready),
    .accept    (accept),
    .hold_full (hold_full),
    .hold_reg  (hold_reg)
  );

  always_comb begin
    shift_nxt = shift_reg;
    if (MSB_FIRST) shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
    else           shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
  end

  // Held word has priority over in_data when free; in_ready is low then anyway.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else begin
      if (last_bit) cnt <= cnt + 1'b1;
      if (free) begin
        if (hold_full) begin
          shift_reg <= hold_reg;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
        end else if (accept) begin
          shift_reg <= in_data;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
        end else begin
          state     <= ST_IDLE;
        end
      end else begin
        shift_reg <= shift_nxt;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_valid  = reset & (state == ST_SHIFT);
  assign ser_bit    = ser_valid ? head : IDLE_BIT;
  assign word_done  = reset & last_bit;
  assign busy       = reset & ((state == ST_SHIFT) | hold_full);
  assign words_sent = cnt;
endmodule

// File: tb/tb_bit_serializer_1011_feed.sv
// Bench: MSB-first (4-bit counter) and LSB-first instances driven in parallel, checked
// against a word-schedule model (each accepted word occupies cycles [start, start+7]).
module tb_bit_serializer_1011_feed;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, ser_bit, ser_valid, word_done, busy;
  logic [3:0] words_sent;
  logic       l_in_ready, l_ser_bit, l_ser_valid, l_word_done, l_busy;
  logic [15:0] l_words_sent;

  bit_serializer_1011_feed #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .word_done(word_done), .busy(busy),
    .words_sent(words_sent)
  );

  bit_serializer_1011_feed #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(16)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
    .ser_bit(l_ser_bit), .ser_valid(l_ser_valid), .word_done(l_word_done), .busy(l_busy),
    .words_sent(l_words_sent)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         t = 0;
  int         st_q[$];
  logic [7:0] dat_q[$];
  int         last_end = -100;
  int         sent = 0;
  logic       exp_bit;
  logic [3:0] obs_hist = 4'h0;
  logic [3:0] exp_hist = 4'h0;
  int         obs_hits = 0;
  int         exp_hits = 0;

  function automatic bit m_hold_full(input int tt);
    foreach (st_q[i]) if (st_q[i] > tt) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_cur(input int tt);
    foreach (st_q[i]) if (st_q[i] <= tt && tt <= st_q[i] + 7) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic check_cycle(input logic r);
    int         idx;
    int         off;
    logic [7:0] w;
    logic       v, mb, lb, wd, hf;
    v = 1'b0; mb = 1'b0; lb = 1'b0; wd = 1'b0; hf = 1'b0;
    if (r) begin
      idx = m_cur(t);
      hf  = m_hold_full(t);
      if (idx >= 0) begin
        w   = dat_q[idx];
        off = t - st_q[idx];
        v   = 1'b1;
        mb  = w[7 - off];
        lb  = w[off];
        wd  = (off == 7);
      end
    end
    exp_bit = mb;
    chk("in_ready",   32'(in_ready),   32'(r & ~hf));
    chk("ser_valid",  32'(ser_valid),  32'(v));
    chk("ser_bit",    32'(ser_bit),    32'(mb));
    chk("word_done",  32'(word_done),  32'(wd));
    chk("busy",       32'(busy),       32'(v | hf));
    chk("words_sent", 32'(words_sent), 32'(sent % 16));
    chk("lsb_ser_valid",  32'(l_ser_valid),  32'(v));
    chk("lsb_ser_bit",    32'(l_ser_bit),    32'(lb));
    chk("lsb_words_sent", 32'(l_words_sent), 32'(sent % 65536));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r, output bit acc);
    int s;
    in_valid = v;
    in_data  = d;
    reset    = r;
    acc = r && v && !m_hold_full(t);
    @(posedge clk);
    if (!r) begin
      st_q.delete();
      dat_q.delete();
      last_end = -100;
      sent = 0;
    end else begin
      foreach (st_q[i]) if (st_q[i] + 7 == t) sent++;
      if (acc) begin
        s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
        st_q.push_back(s);
        dat_q.push_back(d);
        last_end = s + 7;
        if (st_q.size() > 4) begin
          void'(st_q.pop_front());
          void'(dat_q.pop_front());
        end
      end
    end
    t++;
    #1;
    check_cycle(r);
    obs_hist = {obs_hist[2:0], ser_bit};
    exp_hist = {exp_hist[2:0], exp_bit};
    if (obs_hist == DET_PATTERN) obs_hits++;
    if (exp_hist == DET_PATTERN) exp_hits++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, a);
  endtask

  task automatic send(input logic [7:0] d);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, d, 1'b1, a);
    if (!a) begin
      total++;
      bad++;
      $error("FAIL send_timeout word=%0h not accepted within 20 cycles", d);
    end
  endtask

  initial begin
    bit a;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, a);
    idle(2);
    send(8'hB5);
    idle(10);
    send(8'hB0);
    send(8'h0B);
    idle(20);
    send(8'hD0);
    idle(10);
    send(8'hFF);
    send(8'h33);
    idle(2);
    step(1'b0, 8'h00, 1'b0, a);
    idle(12);
    step(1'b0, 8'h00, 1'b0, a);
    for (int i = 0; i < 17; i++) begin
      send(8'($urandom));
      idle(10);
    end
    chk("wrap_17_words", 32'(words_sent), 32'd1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 99) != 0, a);
    idle(12);
    chk("pattern_hits", 32'(obs_hits), 32'(exp_hits));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
